// File: rtl/irda_mir_decoder_if.sv
// Recovered-bit stream from the MIR bit decoder to the MIR deframer.
// Handshake: mir_rx_valid_o is a one-clk strobe qualifying mir_rx_decoded_o; there is no ready,
// the slave must accept every strobe. mir_rx_err_o is an independent one-clk strobe.
interface irda_mir_decoder_if;
  logic mir_rx_decoded_o;
  logic mir_rx_valid_o;
  logic mir_rx_active_o;
  logic mir_rx_err_o;

  modport master (
    output mir_rx_decoded_o,
    output mir_rx_valid_o,
    output mir_rx_active_o,
    output mir_rx_err_o
  );

  modport slave (
    input mir_rx_decoded_o,
    input mir_rx_valid_o,
    input mir_rx_active_o,
    input mir_rx_err_o
  );
endinterface

// File: rtl/irda_mir_decoder.sv
// MIR receive bit decoder: samples the IR line four times per bit, locks its phase counter to
// incoming pulses and emits one recovered bit per bit period (pulse in phase 2 = '0', none = '1').
module irda_mir_decoder #(
  parameter int unsigned IDLE_LIMIT = 7
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic                      mir_rx_i,
  input  logic                      fast_enable,
  input  logic                      mir_mode,
  input  logic                      rx_select,
  irda_mir_decoder_if.master        rx_if,
  output logic                      state_dbg_o
);

  typedef enum logic {
    S_UNLOCKED = 1'b0,
    S_LOCKED   = 1'b1
  } state_e;

  localparam logic [4:0] LIMIT = 5'(IDLE_LIMIT);

  state_e      state_q;
  logic        sync1_q;
  logic        sync_q;
  logic        prev_q;
  logic        pulse_seen_q;
  logic        decoded_q;
  logic        valid_q;
  logic        active_q;
  logic        err_q;
  logic [1:0]  phase_q;
  logic [3:0]  ones_cnt_q;

  logic        en;
  logic        rx_edge;
  logic [1:0]  cur_phase;
  logic [4:0]  ones_inc;

  assign en        = mir_mode & rx_select;
  assign rx_edge   = sync_q & ~prev_q;
  // A pulse always re-anchors the counter to phase 2, even when it arrives out of place.
  assign cur_phase = rx_edge ? 2'd2 : phase_q;
  assign ones_inc  = {1'b0, ones_cnt_q} + 5'd1;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      sync1_q <= mir_rx_i;
      sync_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= S_UNLOCKED;
      prev_q       <= 1'b0;
      pulse_seen_q <= 1'b0;
      decoded_q    <= 1'b0;
      valid_q      <= 1'b0;
      active_q     <= 1'b0;
      err_q        <= 1'b0;
      phase_q      <= 2'd0;
      ones_cnt_q   <= 4'd0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (fast_enable) begin
        prev_q <= sync_q;
      end
      if (!en) begin
        state_q      <= S_UNLOCKED;
        phase_q      <= 2'd0;
        pulse_seen_q <= 1'b0;
        ones_cnt_q   <= 4'd0;
        active_q     <= 1'b0;
      end else if (fast_enable) begin
        unique case (state_q)
          S_UNLOCKED: begin
            if (rx_edge) begin
              state_q      <= S_LOCKED;
              phase_q      <= 2'd3;
              pulse_seen_q <= 1'b1;
              active_q     <= 1'b1;
            end
          end
          S_LOCKED: begin
            phase_q <= cur_phase + 2'd1;
            if (rx_edge) begin
              pulse_seen_q <= 1'b1;
              if (phase_q != 2'd2) begin
                err_q <= 1'b1;
              end
            end
            if (cur_phase == 2'd3) begin
              decoded_q    <= ~pulse_seen_q;
              valid_q      <= 1'b1;
              pulse_seen_q <= 1'b0;
              if (pulse_seen_q) begin
                ones_cnt_q <= 4'd0;
              end else if (ones_inc == LIMIT) begin
                // Long run of ones means the line went idle: emit this bit, then drop lock.
                state_q    <= S_UNLOCKED;
                phase_q    <= 2'd0;
                ones_cnt_q <= 4'd0;
                active_q   <= 1'b0;
              end else if (ones_cnt_q != 4'hF) begin
                ones_cnt_q <= ones_inc[3:0];
              end
            end
          end
          default: state_q <= S_UNLOCKED;
        endcase
      end
    end
  end

  assign rx_if.mir_rx_decoded_o = decoded_q;
  assign rx_if.mir_rx_valid_o   = valid_q;
  assign rx_if.mir_rx_active_o  = active_q;
  assign rx_if.mir_rx_err_o     = err_q;
  assign state_dbg_o            = state_q;

endmodule
